// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: FSM state encoding, default-width
// trace-entry layout and the drop-counter width.
package trace_pkg;

    localparam int unsigned DROP_CNT_W = 16;
    localparam int unsigned INST_W     = 32;

    // Field widths of the default configuration, used by trace_entry_t.
    localparam int unsigned DEF_PC_W   = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HALTED  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [INST_W-1:0]     inst;
        logic                  wb_en;
        logic [DEF_REG_AW-1:0] wb_addr;
        logic [DEF_DATA_W-1:0] wb_data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Entry storage and pointers for the commit trace buffer. A push into a full
// FIFO lands only if a pop happens the same cycle; otherwise it is flagged as dropped.
module trace_fifo #(
    parameter int unsigned WIDTH = 102,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     drop_c_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             empty, full, wr_en, rd_en;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign rd_en    = pop_i & ~empty & ~clear_i;
    assign wr_en    = push_i & (~full | rd_en) & ~clear_i;
    assign drop_c_o = push_i & ~wr_en & ~clear_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(wr_en) - LW'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; empty gating keeps stale data off the output.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = empty ? '0 : mem[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: arms on request, captures retiring instructions into a FIFO,
// halts on an all-zero instruction. Optional PC trigger via TRACE_PC_TRIGGER_EN.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned REG_AW = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              arm,
    input  logic                              clear,
    input  logic                              filter_wb,
    input  logic                              commit_valid,
    input  logic [PC_W-1:0]                   commit_pc,
    input  logic [31:0]                       commit_inst,
    input  logic                              wb_en,
    input  logic [REG_AW-1:0]                 wb_addr,
    input  logic [DATA_W-1:0]                 wb_data,
`ifdef TRACE_PC_TRIGGER_EN
    input  logic [PC_W-1:0]                   trig_pc,
`endif
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [PC_W+33+REG_AW+DATA_W-1:0]  rd_entry,
    output logic [$clog2(DEPTH):0]            level,
    output logic [15:0]                       drop_cnt,
    output logic                              halted
);

    localparam int unsigned ENTRY_W = PC_W + INST_W + 1 + REG_AW + DATA_W;

    trace_state_e            state_q, state_d;
    logic                    push, pop, drop_c;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic [ENTRY_W-1:0]      wr_entry;

    assign wr_entry = {commit_pc, commit_inst, wb_en, wb_addr, wb_data};
    assign pop      = rd_valid & rd_ready;

    // Next state and capture decision; clear overrides everything.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (arm) state_d = ST_ARMED;
                end
                ST_ARMED: begin
`ifdef TRACE_PC_TRIGGER_EN
                    if (commit_valid && (commit_pc == trig_pc)) begin
                        state_d = ST_CAPTURE;
                        push    = 1'b1;
                    end
`else
                    state_d = ST_CAPTURE;
                    push    = commit_valid;
`endif
                end
                ST_CAPTURE: begin
                    if (commit_valid && (commit_inst == '0)) begin
                        state_d = ST_HALTED;
                    end else begin
                        push = commit_valid & (~filter_wb | wb_en);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Saturating count of entries lost to a full FIFO.
    always_comb begin
        drop_d = drop_q;
        if (clear) begin
            drop_d = '0;
        end else if (drop_c && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .clear_i   (clear),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (wr_entry),
        .rd_data_o (rd_entry),
        .level_o   (level),
        .drop_c_o  (drop_c)
    );

    assign rd_valid = (level != '0);
    assign drop_cnt = drop_q;
    assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (DEPTH=4); the PC trigger scenario
// runs only when TRACE_PC_TRIGGER_EN is defined.
module tb_commit_trace_buffer;
    import trace_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         arm, clear, filter_wb, commit_valid, wb_en, rd_ready;
    logic [31:0]  commit_pc, commit_inst, wb_data, trig_pc;
    logic [4:0]   wb_addr;
    logic         rd_valid, halted;
    logic [101:0] rd_entry;
    logic [2:0]   level;
    logic [15:0]  drop_cnt;
    trace_entry_t e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(
        .PC_W   (32),
        .DATA_W (32),
        .DEPTH  (4),
        .REG_AW (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .clear        (clear),
        .filter_wb    (filter_wb),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
`ifdef TRACE_PC_TRIGGER_EN
        .trig_pc      (trig_pc),
`endif
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_entry     (rd_entry),
        .level        (level),
        .drop_cnt     (drop_cnt),
        .halted       (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_commit(input logic [31:0] pc, input logic [31:0] inst,
                             input logic we, input logic [4:0] addr, input logic [31:0] data);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_inst  = inst;
        wb_en        = we;
        wb_addr      = addr;
        wb_data      = data;
        step();
        commit_valid = 1'b0;
    endtask

    // Arm pulse plus one quiet cycle: without the trigger this reaches CAPTURE.
    task automatic arm_and_start();
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
        checks++; if (rd_entry !== '0) begin errors++; $display("FAIL reset_entry got %h want 0", rd_entry); end
    endtask

    task automatic test_in_order();
        logic [31:0] exp_pc;
        trig_pc = 32'h0;
        arm_and_start();
        for (int i = 0; i < 3; i++) begin
            do_commit(32'(4 * i), 32'h00000013, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
            checks++;
            if (level !== 3'(i + 1)) begin errors++; $display("FAIL order_level[%0d] got %0d want %0d", i, level, i + 1); end
        end
        step();
        e = rd_entry;
        checks++; if (e.pc !== 32'h0) begin errors++; $display("FAIL order_hold_pc got %h want 0", e.pc); end
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(4 * i);
            e = rd_entry;
            checks++;
            if (rd_valid !== 1'b1 || e.pc !== exp_pc || e.inst !== 32'h13 || e.wb_data !== 32'h100 + 32'(i)) begin
                errors++;
                $display("FAIL order_entry[%0d] got v=%0b pc=%h inst=%h data=%h want pc=%h", i, rd_valid, e.pc, e.inst, e.wb_data, exp_pc);
            end
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        checks++; if (rd_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL order_drained got v=%0b lvl=%0d want 0 0", rd_valid, level); end
        do_clear();
    endtask

    task automatic test_filter();
        filter_wb = 1'b1;
        trig_pc   = 32'h100;
        arm_and_start();
        do_commit(32'h100, 32'h13, 1'b1, 5'd3, 32'hA0);
        do_commit(32'h104, 32'h13, 1'b0, 5'd4, 32'hA1);
        do_commit(32'h108, 32'h13, 1'b1, 5'd5, 32'hA2);
        do_commit(32'h10C, 32'h13, 1'b0, 5'd6, 32'hA3);
        filter_wb = 1'b0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL filter_level got %0d want 2", level); end
        e = rd_entry;
        checks++;
        if (e.pc !== 32'h100 || e.wb_en !== 1'b1 || e.wb_addr !== 5'd3 || e.wb_data !== 32'hA0) begin
            errors++; $display("FAIL filter_first got pc=%h we=%0b a=%0d d=%h want 100 1 3 a0", e.pc, e.wb_en, e.wb_addr, e.wb_data);
        end
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        e = rd_entry;
        checks++;
        if (e.pc !== 32'h108 || e.wb_en !== 1'b1 || e.wb_addr !== 5'd5 || e.wb_data !== 32'hA2) begin
            errors++; $display("FAIL filter_second got pc=%h we=%0b a=%0d d=%h want 108 1 5 a2", e.pc, e.wb_en, e.wb_addr, e.wb_data);
        end
        do_clear();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h204; exp_pc[1] = 32'h208; exp_pc[2] = 32'h20C; exp_pc[3] = 32'h218;
        trig_pc = 32'h200;
        arm_and_start();
        for (int i = 0; i < 6; i++) do_commit(32'h200 + 32'(4 * i), 32'h13, 1'b1, 5'd1, 32'(i));
        checks++; if (level !== 3'd4 || drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_full got lvl=%0d drop=%0d want 4 2", level, drop_cnt); end
        rd_ready = 1'b1;
        do_commit(32'h218, 32'h13, 1'b1, 5'd1, 32'h6);
        rd_ready = 1'b0;
        checks++; if (level !== 3'd4 || drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_pushpop got lvl=%0d drop=%0d want 4 2", level, drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            e = rd_entry;
            checks++; if (e.pc !== exp_pc[i]) begin errors++; $display("FAIL ovf_wrap[%0d] got pc=%h want %h", i, e.pc, exp_pc[i]); end
            rd_ready = 1'b1; step(); rd_ready = 1'b0;
        end
        // Empty FIFO: simultaneous push and pop leaves just the push.
        rd_ready = 1'b1;
        do_commit(32'h21C, 32'h13, 1'b1, 5'd1, 32'h7);
        rd_ready = 1'b0;
        e = rd_entry;
        checks++; if (level !== 3'd1 || e.pc !== 32'h21C) begin errors++; $display("FAIL empty_pushpop got lvl=%0d pc=%h want 1 21c", level, e.pc); end
        do_clear();
    endtask

    task automatic test_halt();
        trig_pc = 32'h300;
        arm_and_start();
        do_commit(32'h300, 32'h13, 1'b1, 5'd2, 32'h1);
        do_commit(32'h304, 32'h0, 1'b1, 5'd2, 32'h2);
        checks++; if (halted !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL halt_enter got h=%0b lvl=%0d want 1 1", halted, level); end
        do_commit(32'h308, 32'h13, 1'b1, 5'd2, 32'h3);
        checks++; if (halted !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL halt_ignore got h=%0b lvl=%0d want 1 1", halted, level); end
        trig_pc = 32'h30C;
        arm_and_start();
        checks++; if (halted !== 1'b0 || level !== 3'd1) begin errors++; $display("FAIL halt_rearm got h=%0b lvl=%0d want 0 1", halted, level); end
        do_commit(32'h30C, 32'h13, 1'b1, 5'd2, 32'h4);
        e = rd_entry;
        checks++; if (level !== 3'd2 || e.pc !== 32'h300) begin errors++; $display("FAIL halt_resume got lvl=%0d pc=%h want 2 300", level, e.pc); end
        do_clear();
    endtask

`ifdef TRACE_PC_TRIGGER_EN
    task automatic test_trigger();
        trig_pc = 32'h00400010;
        arm_and_start();
        do_commit(32'h00400008, 32'h13, 1'b1, 5'd1, 32'h0);
        do_commit(32'h0040000C, 32'h13, 1'b1, 5'd1, 32'h0);
        do_commit(32'h00400010, 32'h13, 1'b1, 5'd1, 32'h0);
        do_commit(32'h00400014, 32'h13, 1'b1, 5'd1, 32'h0);
        e = rd_entry;
        checks++; if (level !== 3'd2 || e.pc !== 32'h00400010) begin errors++; $display("FAIL trigger got lvl=%0d pc=%h want 2 00400010", level, e.pc); end
        do_clear();
    endtask
`endif

    task automatic test_clear_reset();
        trig_pc = 32'h400;
        arm_and_start();
        for (int i = 0; i < 3; i++) do_commit(32'h400 + 32'(4 * i), 32'h13, 1'b1, 5'd1, 32'h0);
        clear = 1'b1; step(); clear = 1'b0;
        checks++; if (rd_valid !== 1'b0 || level !== 3'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL clear_mid got v=%0b lvl=%0d drop=%0d want 0 0 0", rd_valid, level, drop_cnt); end
        do_commit(32'h40C, 32'h13, 1'b1, 5'd1, 32'h0);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL clear_idle got lvl=%0d want 0", level); end
        trig_pc = 32'h500;
        arm_and_start();
        for (int i = 0; i < 6; i++) do_commit(32'h500 + 32'(4 * i), 32'h13, 1'b1, 5'd1, 32'h0);
        rst = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || level !== 3'd0 || drop_cnt !== 16'd0 || rd_entry !== '0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_mid got v=%0b lvl=%0d drop=%0d h=%0b want 0 0 0 0", rd_valid, level, drop_cnt, halted);
        end
        step();
        rst = 1'b1;
        do_commit(32'h600, 32'h13, 1'b1, 5'd1, 32'h0);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_idle got lvl=%0d want 0", level); end
    endtask

    initial begin
        rst = 1'b0; arm = 1'b0; clear = 1'b0; filter_wb = 1'b0; commit_valid = 1'b0;
        wb_en = 1'b0; rd_ready = 1'b0; commit_pc = '0; commit_inst = '0;
        wb_data = '0; wb_addr = '0; trig_pc = '0;
        step(); step();
        test_reset();
        rst = 1'b1;
        step();
        test_in_order();
        test_filter();
        test_overflow();
        test_halt();
`ifdef TRACE_PC_TRIGGER_EN
        test_trigger();
`endif
        test_clear_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter PC_W, default 32, program-counter width.
REQ-002 Parameter DATA_W, default 32, register write-back data width.
REQ-003 Parameter DEPTH, default 16, number of trace entries; power of two, at least 2.
REQ-004 Parameter REG_AW, default 5, register-file address width.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports SHALL be, in order:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- arm  in  1  start-capture pulse.
- clear  in  1  synchronous flush.
- filter_wb  in  1  capture only commits that write a register.
- commit_valid  in  1  an instruction retires this cycle.
- commit_pc  in  PC_W  PC of the retiring instruction.
- commit_inst  in  32  retiring instruction word.
- wb_en  in  1  register write enable.
- wb_addr  in  REG_AW  register write address.
- wb_data  in  DATA_W  register write data.
- trig_pc  in  PC_W  trigger PC (macro only).
- rd_valid  out  1  entry available.
- rd_ready  in  1  consumer accepts the entry.
- rd_entry  out  PC_W+33+REG_AW+DATA_W  head entry {pc, inst, wb_en, wb_addr, wb_data}.
- level  out  clog2(DEPTH)+1  occupancy.
- drop_cnt  out  16  count of dropped entries.
- halted  out  1  state is HALTED.

Function
REQ-007 The FSM SHALL have four states: IDLE, ARMED, CAPTURE and HALTED.
REQ-008 From IDLE or HALTED, arm=1 SHALL move the FSM to ARMED.
- arm is ignored in ARMED and CAPTURE.
- FIFO contents are retained.
REQ-009 Capturing commit: commit_valid=1 and (filter_wb=0 or wb_en=1) while in CAPTURE, or the triggering commit of REQ-011.
REQ-010 A capturing commit SHALL write one entry.
- The entry is readable (rd_valid=1) from the cycle after the write edge; latency is 1.
REQ-011 Leaving ARMED SHALL follow the Configuration rules. A commit that moves the FSM from ARMED to CAPTURE SHALL itself be captured.
REQ-012 commit_valid=1 with commit_inst=0 in CAPTURE SHALL move the FSM to HALTED. That commit is not written.
REQ-013 The read side SHALL be a FIFO.
- rd_valid = level!=0.
- Pop on rd_valid and rd_ready.
- rd_entry is the oldest entry and is stable while rd_valid=1 and rd_ready=0.
REQ-014 Push when full without a same-cycle pop SHALL drop the new entry and increment drop_cnt. drop_cnt saturates at 0xFFFF.
REQ-015 Push and pop in the same cycle when full SHALL both occur, with no drop and level unchanged.
REQ-016 Push and pop in the same cycle when empty SHALL perform only the push.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH.
REQ-018 clear=1 SHALL have priority over all other inputs. It sets state=IDLE, level=0, pointers=0 and drop_cnt=0 at the next edge.

Reset
REQ-019 While rst=0, the block SHALL hold:
- state=IDLE;
- pointers, level and drop_cnt at 0;
- rd_valid=0, halted=0, rd_entry=0.
REQ-020 Storage RAM SHALL NOT be reset.
REQ-021 Reset asserted mid-capture SHALL discard all entries. Deassertion is synchronised to clk by the user.

Configuration
REQ-022 Macro TRACE_PC_TRIGGER_EN defined: the trig_pc port SHALL exist, and ARMED moves to CAPTURE on commit_valid=1 with commit_pc==trig_pc.
REQ-023 Macro TRACE_PC_TRIGGER_EN undefined: the trig_pc port SHALL be absent, and ARMED moves to CAPTURE at the next edge unconditionally.

Structure
REQ-024 Package trace_pkg SHALL hold:
- the FSM state enum;
- the trace-entry packed struct type;
- DROP_CNT_W=16.
REQ-025 Storage and pointers SHALL live in sub-module trace_fifo. The FSM, filter and counters SHALL live in the top level.

Verification
REQ-026 Trigger disabled: arm, then 3 commits with pc 0x0,0x4,0x8 -> 3 entries read back in order, with level stepping 1,2,3.
REQ-027 filter_wb=1: 4 commits with wb_en=1,0,1,0 -> 2 entries (1st and 3rd), carrying wb_addr/wb_data as driven.
REQ-028 DEPTH=4, rd_ready=0, 6 commits -> level=4 and drop_cnt=2; then rd_ready=1 plus one commit in the same cycle -> level stays 4 and drop_cnt stays 2.
REQ-029 Commit with inst=0x00000000 -> halted=1 next cycle, no entry written, and later commits ignored until arm.
REQ-030 TRACE_PC_TRIGGER_EN, trig_pc=0x00400010: commits at 0x...08, 0x...0C and 0x...10 -> first entry pc=0x00400010.
REQ-031 Reset and clear mid-capture with 3 entries held -> rd_valid=0, level=0 and drop_cnt=0 on the next cycle; for reset, immediately.
